// File: rtl/bcd_counter_chain.sv
// Multi-digit modulo counter: NUM_DIGITS radix-RADIX digit cells with up/down,
// parallel load, synchronous clear, combinational terminal count, registered wrap pulse.
module bcd_counter_chain #(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned RADIX      = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    cin,
  input  logic                    up,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_val,
  output logic [4*NUM_DIGITS-1:0] q,
  output logic                    tc,
  output logic                    cout,
  output logic                    ovf
);

  localparam int unsigned W    = 4 * NUM_DIGITS;
  localparam logic [3:0]  DMAX = 4'(RADIX - 1);
  localparam logic [4:0]  RAD5 = 5'(RADIX);

  logic [W-1:0] q_step;
  logic [W-1:0] q_load;
  logic         step;
  logic         terminal;
  logic         chain;
  logic [3:0]   dig;

  assign step = en & cin;
  assign tc   = step & terminal;

  // A digit moves only when every lower digit sits at its limit for this direction.
  always_comb begin
    chain  = 1'b1;
    dig    = 4'd0;
    q_step = q;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      dig = q[4*i +: 4];
      if (chain) begin
        if (up) q_step[4*i +: 4] = (dig == DMAX) ? 4'd0 : dig + 4'd1;
        else    q_step[4*i +: 4] = (dig == 4'd0) ? DMAX : dig - 4'd1;
      end
      chain = chain & (dig == (up ? DMAX : 4'd0));
    end
    terminal = chain;
  end

  // Out-of-range load digits saturate to the top legal value.
  always_comb begin
    q_load = load_val;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if ({1'b0, load_val[4*i +: 4]} >= RAD5) q_load[4*i +: 4] = DMAX;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (clr) begin
      q    <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else if (load) begin
      q    <= q_load;
      cout <= 1'b0;
    end else begin
      cout <= tc;
      if (tc)   ovf <= 1'b1;
      if (step) q   <= q_step;
    end
  end

endmodule

// File: tb/tb_bcd_counter_chain.sv
// Scoreboard bench for bcd_counter_chain: decimal pair, radix-6/radix-10 cascade and
// 3-digit hex instance, all checked against an integer modulo reference model.
module tb_bcd_counter_chain;

  logic        clk, rst, clr, en, cin, up, load;
  logic [7:0]  lv_main, lv_lo, lv_hi;
  logic [11:0] lv_hex;
  logic [7:0]  q_main, q_lo, q_hi;
  logic [11:0] q_hex;
  logic        tc_main, tc_lo, tc_hi, tc_hex;
  logic        co_main, co_lo, co_hi, co_hex;
  logic        ov_main, ov_lo, ov_hi, ov_hex;

  bcd_counter_chain #(.NUM_DIGITS(2), .RADIX(10)) u_main (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .cin(cin), .up(up), .load(load),
    .load_val(lv_main), .q(q_main), .tc(tc_main), .cout(co_main), .ovf(ov_main));

  bcd_counter_chain #(.NUM_DIGITS(2), .RADIX(6)) u_lo (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .cin(cin), .up(up), .load(load),
    .load_val(lv_lo), .q(q_lo), .tc(tc_lo), .cout(co_lo), .ovf(ov_lo));

  bcd_counter_chain #(.NUM_DIGITS(2), .RADIX(10)) u_hi (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .cin(tc_lo), .up(up), .load(load),
    .load_val(lv_hi), .q(q_hi), .tc(tc_hi), .cout(co_hi), .ovf(ov_hi));

  bcd_counter_chain #(.NUM_DIGITS(3), .RADIX(16)) u_hex (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .cin(cin), .up(up), .load(load),
    .load_val(lv_hex), .q(q_hex), .tc(tc_hex), .cout(co_hex), .ovf(ov_hex));

  typedef struct {
    logic [7:0]  q_main;
    bit          tc_main, co_main, ov_main;
    logic [15:0] q_cas;
    bit          tc_cas, co_cas, ov_cas;
    logic [11:0] q_hex;
    bit          tc_hex, co_hex, ov_hex;
  } exp_t;

  exp_t sb[$];
  int   checks, failures;
  int   v_main, v_cas, v_hex;
  bit   o_main, o_cas, o_hex;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  // Value of a packed digit vector, saturating out-of-range digits.
  function automatic int sat_val(logic [31:0] p, int n, int r);
    int v, d;
    v = 0;
    for (int i = n - 1; i >= 0; i--) begin
      d = int'(p[4*i +: 4]);
      if (d >= r) d = r - 1;
      v = v * r + d;
    end
    return v;
  endfunction

  function automatic logic [31:0] pack(int v, int n, int r);
    logic [31:0] p;
    int t;
    p = '0;
    t = v;
    for (int i = 0; i < n; i++) begin
      p[4*i +: 4] = 4'(t % r);
      t = t / r;
    end
    return p;
  endfunction

  // Reference: one counter is a single integer modulo m.
  task automatic model_step(inout int v, inout bit o, output bit t, output bit c,
                            input int m, input int ldv);
    bit s;
    s = en & cin;
    t = s && (up ? (v == m - 1) : (v == 0));
    if (clr) begin
      v = 0; o = 1'b0; c = 1'b0;
    end else if (load) begin
      v = ldv; c = 1'b0;
    end else begin
      c = t;
      if (t) o = 1'b1;
      if (s) v = up ? (v + 1) % m : (v + m - 1) % m;
    end
  endtask

  task automatic cyc(input bit c_clr, input bit c_load, input bit c_en, input bit c_cin,
                     input bit c_up, input logic [7:0] l_main, input logic [11:0] l_hex);
    exp_t e;
    @(negedge clk);
    clr = c_clr; load = c_load; en = c_en; cin = c_cin; up = c_up;
    lv_main = l_main; lv_lo = l_main; lv_hi = {l_main[3:0], l_main[7:4]}; lv_hex = l_hex;
    model_step(v_main, o_main, e.tc_main, e.co_main, 100, sat_val(32'(l_main), 2, 10));
    model_step(v_cas, o_cas, e.tc_cas, e.co_cas, 3600,
               sat_val(32'(lv_hi), 2, 10) * 36 + sat_val(32'(l_main), 2, 6));
    model_step(v_hex, o_hex, e.tc_hex, e.co_hex, 4096, sat_val(32'(l_hex), 3, 16));
    e.q_main = 8'(pack(v_main, 2, 10));
    e.ov_main = o_main;
    e.q_cas  = {8'(pack(v_cas / 36, 2, 10)), 8'(pack(v_cas % 36, 2, 6))};
    e.ov_cas = o_cas;
    e.q_hex  = 12'(pack(v_hex, 3, 16));
    e.ov_hex = o_hex;
    sb.push_back(e);
  endtask

  // Monitor: tc sampled before the edge, registered outputs after it.
  initial begin
    bit   s_main, s_cas, s_hex;
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      s_main = tc_main; s_cas = tc_hi; s_hex = tc_hex;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("main.tc",   32'(s_main),  32'(e.tc_main));
        chk("main.q",    32'(q_main),  32'(e.q_main));
        chk("main.cout", 32'(co_main), 32'(e.co_main));
        chk("main.ovf",  32'(ov_main), 32'(e.ov_main));
        chk("cas.tc",    32'(s_cas),   32'(e.tc_cas));
        chk("cas.q",     32'({q_hi, q_lo}), 32'(e.q_cas));
        chk("cas.cout",  32'(co_hi),   32'(e.co_cas));
        chk("cas.ovf",   32'(ov_hi),   32'(e.ov_cas));
        chk("hex.tc",    32'(s_hex),   32'(e.tc_hex));
        chk("hex.q",     32'(q_hex),   32'(e.q_hex));
        chk("hex.cout",  32'(co_hex),  32'(e.co_hex));
        chk("hex.ovf",   32'(ov_hex),  32'(e.ov_hex));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         dir;
    logic [7:0] r8;
    logic [11:0] r12;
    checks = 0; failures = 0;
    v_main = 0; v_cas = 0; v_hex = 0;
    o_main = 1'b0; o_cas = 1'b0; o_hex = 1'b0;
    rst = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b1; cin = 1'b1; up = 1'b0;
    lv_main = '0; lv_lo = '0; lv_hi = '0; lv_hex = '0;

    // Reset state; tc still follows its inputs (all-zero is terminal when counting down).
    #3;
    chk("reset.q",    32'(q_main),  32'h00);
    chk("reset.cout", 32'(co_main), 32'h0);
    chk("reset.ovf",  32'(ov_main), 32'h0);
    chk("reset.tc",   32'(tc_main), 32'h1);
    chk("reset.hexq", 32'(q_hex),   32'h000);
    en = 1'b0; cin = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Up wrap 98 -> 99 -> 00 -> 01; hex FFE -> FFF -> 000 -> 001.
    cyc(0, 1, 1, 1, 1, 8'h98, 12'hFFE);
    repeat (3) cyc(0, 0, 1, 1, 1, 8'h00, 12'h000);
    cyc(0, 0, 0, 1, 1, 8'h00, 12'h000);

    // Down borrow 10 -> 09 -> 08, then 00 -> 99 with wrap pulse.
    cyc(1, 0, 0, 0, 0, 8'h00, 12'h000);
    cyc(0, 1, 1, 1, 0, 8'h10, 12'h010);
    repeat (2) cyc(0, 0, 1, 1, 0, 8'h00, 12'h000);
    cyc(0, 1, 0, 0, 0, 8'h00, 12'h000);
    cyc(0, 0, 1, 1, 0, 8'h00, 12'h000);
    cyc(0, 0, 1, 0, 0, 8'h00, 12'h000);

    // Priority: clr over load over step; then saturating load with step requested.
    cyc(1, 1, 1, 1, 1, 8'h55, 12'h555);
    cyc(0, 1, 1, 1, 1, 8'hA7, 12'hAB7);

    // Count 97 up through a wrap to 37, then reset asynchronously mid-cycle.
    repeat (40) cyc(0, 0, 1, 1, 1, 8'h00, 12'h000);
    @(negedge clk);
    en = 1'b0; cin = 1'b0; load = 1'b0; clr = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst.q",    32'(q_main),  32'h00);
    chk("arst.cout", 32'(co_main), 32'h0);
    chk("arst.ovf",  32'(ov_main), 32'h0);
    chk("arst.casq", 32'({q_hi, q_lo}), 32'h0000);
    v_main = 0; v_cas = 0; v_hex = 0;
    o_main = 1'b0; o_cas = 1'b0; o_hex = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Randomized enable/carry/direction with occasional loads and clears.
    dir = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      r8  = 8'($urandom);
      r12 = 12'($urandom);
      if ($urandom_range(49) == 0) dir = ~dir;
      cyc(($urandom_range(63) == 0), ($urandom_range(31) == 0),
          ($urandom_range(3) != 0), ($urandom_range(3) != 0), dir, r8, r12);
    end
    cyc(0, 0, 0, 0, 1, 8'h00, 12'h000);

    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    #2;
    chk("drain", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bcd_counter_chain.md
Name: bcd_counter_chain

Overview:
- Parametrised multi-digit modulo counter, built as a cascade of NUM_DIGITS radix-RADIX digit cells (default: 2-digit decimal, 00..99).
- Single-digit decade cells in the display/timer path move onto this block; added features: up/down counting, parallel load, synchronous clear and sticky overflow.
- Exposes a registered wrap pulse and a same-cycle terminal-count output, so instances cascade into wider counters or timers.

Parameters:
- NUM_DIGITS, 2, number of 4-bit digit cells (1..8).
- RADIX, 10, modulus of every digit (2..16); digit legal range 0..RADIX-1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  synchronous clear of count and ovf.
- en  in  1  count enable.
- cin  in  1  carry/borrow in. A step occurs only when en=1 and cin=1. Tie high for a free-running counter.
- up  in  1  direction: 1 = increment, 0 = decrement.
- load  in  1  synchronous parallel load.
- load_val  in  4*NUM_DIGITS  load value, digit i in bits [4i+3:4i].
- q  out  4*NUM_DIGITS  current count, same packing (digit 0 = least significant).
- tc  out  1  combinational terminal count: en & cin & all digits terminal for the current direction.
- cout  out  1  registered one-cycle pulse: the counter wrapped on the previous edge.
- ovf  out  1  sticky wrap flag.

Behaviour:
- Reset (rst=1, asynchronous): q=0, cout=0, ovf=0. tc follows from its inputs.
- Per-edge priority: rst > clr > load > step > hold.
- clr=1: q=0, cout=0, ovf=0.
- load=1 (clr=0):
  - q <= load_val, except a digit >= RADIX is saturated to RADIX-1.
  - cout=0; ovf unchanged; no step taken even if en&cin.
- Step, up=1:
  - Digit 0 increments.
  - Digit i>0 increments iff every lower digit == RADIX-1.
  - A digit at RADIX-1 that increments becomes 0.
- Step, up=0:
  - Digit 0 decrements.
  - Digit i>0 decrements iff every lower digit == 0.
  - A digit at 0 that decrements becomes RADIX-1.
- Terminal state: all digits RADIX-1 when up=1; all digits 0 when up=0.
- tc = en & cin & terminal. Purely combinational, zero latency, intended to drive the next instance's cin.
- cout <= tc on every edge where no rst/clr/load applies; otherwise cout <= 0.
  - Result: cout is high exactly one cycle after a wrap edge, for exactly one cycle (unless wrapping repeats).
- ovf <= 1 on any wrap edge. Holds until clr or rst; load does not clear it.
- en=0 or cin=0: q holds, cout <= 0.
- Direction change takes effect on the same edge; no pipeline state.
- Illegal digit values are unreachable; behaviour with them present is not required.
- NUM_DIGITS=1, RADIX=10 reduces to a single decade counter with registered carry.
- All arithmetic is per digit, 4-bit, compare-to-limit; no binary-to-BCD conversion.

Test Plan:
1. Reset mid-count:
   - Stimulus: count to q=0x37, assert rst asynchronously between edges.
   - Required: q=0x00, cout=0, ovf=0 immediately, without a clock edge.
2. Up wrap:
   - Stimulus: defaults; load 0x98; en=cin=up=1 for 3 edges.
   - Required: q=0x99, tc=1, q=0x00, then 0x01.
   - Required: cout=1 only in the cycle q=0x00; ovf=1 from that cycle until clr.
3. Down borrow:
   - Stimulus: load 0x10, up=0, step 2.
   - Required: q=0x09, then 0x08.
   - Then load 0x00 and step once: tc=1 before the edge, q=0x99 after, cout pulse, ovf=1.
4. Priority and saturation:
   - Stimulus: same edge with clr=1, load=1, en=cin=1: q=0x00, ovf cleared.
   - Stimulus: load=1 with load_val=0xA7 and en=cin=1: q=0x97, no step.
5. Hold and cascade:
   - Stimulus: two instances (NUM_DIGITS=2, RADIX=6 and RADIX=10), tc of the low instance driving cin of the high one. Toggle en/cin pseudo-randomly for 1000 cycles.
   - Required: combined value matches a reference model; no change when en=0 or cin=0.
6. RADIX=16, NUM_DIGITS=3:
   - Stimulus: load 0xFFE, up=1, step 2.
   - Required: q=0xFFF, then 0x000 with a cout pulse.
